// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive sequencer and its line/checker logic.
// "master" drives the line and checker results; "slave" is the sequencer side.
interface uart_rx_fsm_if #(
    parameter int PRESCALE_BITS = 6,
    parameter int TX_BITS       = 4
);
    logic                     RX_IN;
    logic                     PAR_EN;
    logic [PRESCALE_BITS-1:0] Prescale;
    logic                     strt_glitch;
    logic                     par_err;
    logic                     stp_err;

    logic [PRESCALE_BITS-1:0] edge_cnt;
    logic [TX_BITS-1:0]       bit_cnt;
    logic                     dat_samp_en;
    logic                     deser_en;
    logic                     strt_chk_en;
    logic                     par_chk_en;
    logic                     stp_chk_en;
    // Single-cycle pulse, no back-pressure: a receiver must take it when it is high.
    logic                     data_valid;
    logic [2:0]               fsm_state;

    modport master (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, fsm_state
    );

    modport slave (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, fsm_state
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks START/DATA/PARITY/STOP on an oversample tick
// counter and raises data_valid for one cycle after an error-free frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH    = 8,
    parameter int PRESCALE_BITS = 6,
    parameter int TX_BITS       = 4
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fsm_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [TX_BITS-1:0]       LAST_DATA = TX_BITS'(DATA_WIDTH);
    localparam logic [TX_BITS-1:0]       BIT_ONE   = TX_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] EDGE_ONE  = PRESCALE_BITS'(1);

    state_t                   state, state_nxt;
    logic [PRESCALE_BITS-1:0] edge_cnt, edge_nxt;
    logic [TX_BITS-1:0]       bit_cnt, bit_nxt;
    logic                     par_flag, par_flag_nxt;
    logic                     data_valid, data_valid_nxt;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_nxt;
    logic                     par_en_q, par_en_nxt;
    logic                     armed;
    logic [PRESCALE_BITS-1:0] eff_prescale;
    logic [PRESCALE_BITS-1:0] last_tick;
    logic                     end_of_bit;

    // The first clock after reset release only arms the block, so a low line
    // at release cannot start a frame until the second edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            par_flag   <= 1'b0;
            data_valid <= 1'b0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            armed      <= 1'b0;
        end else if (!armed) begin
            armed      <= 1'b1;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            par_flag   <= par_flag_nxt;
            data_valid <= data_valid_nxt;
            prescale_q <= prescale_nxt;
            par_en_q   <= par_en_nxt;
        end
    end

    // The start bit runs on the live ratio; it is frozen once data begins.
    assign eff_prescale = (state == START) ? bus.Prescale : prescale_q;
    assign last_tick    = eff_prescale - EDGE_ONE;
    assign end_of_bit   = (edge_cnt == last_tick);

    always_comb begin
        state_nxt      = state;
        edge_nxt       = edge_cnt;
        bit_nxt        = bit_cnt;
        par_flag_nxt   = par_flag;
        data_valid_nxt = 1'b0;
        prescale_nxt   = prescale_q;
        par_en_nxt     = par_en_q;

        if (state != IDLE) begin
            if (end_of_bit) begin
                edge_nxt = '0;
                bit_nxt  = bit_cnt + BIT_ONE;
            end else begin
                edge_nxt = edge_cnt + EDGE_ONE;
            end
        end

        case (state)
            IDLE: begin
                edge_nxt     = '0;
                bit_nxt      = '0;
                par_flag_nxt = 1'b0;
                if (!bus.RX_IN) state_nxt = START;
            end
            START: begin
                if (end_of_bit) begin
                    if (bus.strt_glitch) begin
                        state_nxt = IDLE;
                        edge_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt    = DATA;
                        prescale_nxt = bus.Prescale;
                        par_en_nxt   = bus.PAR_EN;
                    end
                end
            end
            DATA: begin
                if (end_of_bit && bit_cnt == LAST_DATA)
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (end_of_bit) begin
                    par_flag_nxt = bus.par_err;
                    state_nxt    = STOP;
                end
            end
            STOP: begin
                if (end_of_bit) begin
                    state_nxt      = IDLE;
                    data_valid_nxt = !bus.stp_err && !par_flag;
                    edge_nxt       = '0;
                    bit_nxt        = '0;
                    par_flag_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                edge_nxt     = '0;
                bit_nxt      = '0;
                par_flag_nxt = 1'b0;
            end
        endcase
    end

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.dat_samp_en = (state != IDLE);
    assign bus.strt_chk_en = (state == START);
    assign bus.deser_en    = (state == DATA);
    assign bus.par_chk_en  = (state == PARITY);
    assign bus.stp_chk_en  = (state == STOP);
    assign bus.data_valid  = data_valid;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame table, reset corner cases and random frames,
// each cycle compared with a frame-timing model computed from tick arithmetic.
module tb_uart_rx_fsm;
    localparam int DW = 8;
    localparam int PB = 6;
    localparam int TB = 4;
    localparam int NV = 11;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_rx_fsm_if #(.PRESCALE_BITS(PB), .TX_BITS(TB)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_BITS(PB), .TX_BITS(TB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [PB-1:0] edge_c;
        logic [TB-1:0] bit_c;
        logic          samp;
        logic          deser;
        logic          strt;
        logic          par;
        logic          stp;
        logic          dv;
    } outs_t;

    typedef struct {
        int             p;
        bit             pen;
        logic [DW-1:0]  data;
        bit             glitch;
        bit             perr;
        bit             serr;
        bit             noise;
        bit             b2b;
        bit             exp_dv;
        int             exp_deser;
    } vec_t;

    outs_t act;
    assign act = {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.deser_en,
                  bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid};

    int   n_vec = 0;
    int   n_err = 0;
    logic dv_exp_q[$];
    int   dv_times[$];
    int   cyc = 0;
    vec_t vecs[NV];

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (bus.data_valid === 1'b1) dv_times.push_back(cyc);

    task automatic cmp_out(input string name, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h (state %0d)",
                     name, $time, act, exp, bus.fsm_state);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [PB-1:0] rand_presc();
        case ($urandom_range(0, 2))
            0:       return PB'(8);
            1:       return PB'(16);
            default: return PB'(32);
        endcase
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Cycle k counted from START entry: bit k/p, tick k%p; the bit index names the phase.
    function automatic outs_t model_at(input int k, input int p, input bit pen);
        outs_t o;
        int    b;
        b = k / p;
        o = '0;
        o.edge_c = PB'(k % p);
        o.bit_c  = TB'(b);
        o.samp   = 1'b1;
        if (b == 0)                    o.strt  = 1'b1;
        else if (b <= DW)              o.deser = 1'b1;
        else if (pen && b == DW + 1)   o.par   = 1'b1;
        else                           o.stp   = 1'b1;
        return o;
    endfunction

    function automatic outs_t idle_exp(input logic dv);
        outs_t o;
        o = '0;
        o.dv = dv;
        return o;
    endfunction

    function automatic logic pop_dv();
        if (dv_exp_q.size() == 0) return 1'b0;
        return dv_exp_q.pop_front();
    endfunction

    task automatic drive_idle_inputs(input logic rx);
        bus.RX_IN       = rx;
        bus.PAR_EN      = rbit();
        bus.Prescale    = rand_presc();
        bus.strt_glitch = rbit();
        bus.par_err     = rbit();
        bus.stp_err     = rbit();
    endtask

    // One IDLE cycle: check it (collecting any data_valid owed by the last
    // frame), then hold the line at rx for the coming edge.
    task automatic idle_cycle(input logic rx);
        cmp_out("idle", idle_exp(pop_dv()));
        drive_idle_inputs(rx);
        @(posedge CLK); #1;
    endtask

    // Steps a frame from START entry; stops early (no result queued) at abort_k.
    task automatic run_body(input int p, input bit pen, input logic [DW-1:0] data,
                            input bit glitch, input bit perr, input bit serr,
                            input bit noise, input bit exp_dv, input int abort_k,
                            output int deser_seen);
        int len, b, e;
        len = glitch ? p : (DW + 2 + int'(pen)) * p;
        deser_seen = 0;
        for (int k = 0; k < len; k++) begin
            if (k == abort_k) return;
            b = k / p;
            e = k % p;
            cmp_out("frame", model_at(k, p, pen));
            if (bus.deser_en === 1'b1) deser_seen++;

            if (b == 0)                  bus.RX_IN = 1'b0;
            else if (noise)              bus.RX_IN = rbit();
            else if (b <= DW)            bus.RX_IN = data[b-1];
            else if (pen && b == DW + 1) bus.RX_IN = ^data;
            else                         bus.RX_IN = 1'b1;

            if (b == 0 || !noise) begin
                bus.Prescale = PB'(p);
                bus.PAR_EN   = pen;
            end else begin
                bus.Prescale = rand_presc();
                bus.PAR_EN   = rbit();
            end
            bus.strt_glitch = (noise && !(b == 0 && e == p - 1)) ? rbit() : glitch;
            bus.par_err     = (noise && !(pen && b == DW + 1 && e == p - 1)) ? rbit() : perr;
            bus.stp_err     = (noise && k != len - 1) ? rbit() : serr;
            @(posedge CLK); #1;
        end
        dv_exp_q.push_back(exp_dv);
    endtask

    initial begin
        int seen;
        int mark;

        //          p  pen data   gl pe se nz b2b dv deser
        vecs[0]  = '{8,  0, 8'hA5, 0, 0, 0, 0, 0, 1, 64};
        vecs[1]  = '{16, 1, 8'h3C, 0, 1, 0, 0, 0, 0, 128};
        vecs[2]  = '{8,  0, 8'h00, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{32, 0, 8'h01, 0, 0, 0, 0, 0, 1, 256};
        vecs[4]  = '{32, 0, 8'hFE, 0, 0, 0, 0, 1, 1, 256};
        vecs[5]  = '{16, 1, 8'h77, 0, 0, 1, 0, 0, 0, 128};
        vecs[6]  = '{16, 1, 8'h81, 0, 0, 0, 0, 1, 1, 128};
        vecs[7]  = '{8,  0, 8'h42, 0, 1, 0, 0, 0, 1, 64};
        vecs[8]  = '{16, 1, 8'h99, 0, 0, 0, 1, 0, 1, 128};
        vecs[9]  = '{32, 1, 8'hE7, 0, 1, 1, 1, 1, 0, 256};
        vecs[10] = '{8,  0, 8'h5A, 1, 0, 0, 1, 0, 0, 0};
        mark = 0;

        RST = 1'b0;
        drive_idle_inputs(1'b0);
        repeat (2) @(posedge CLK);
        #1 cmp_out("reset", idle_exp(1'b0));
        @(negedge CLK);
        RST = 1'b1;
        bus.RX_IN = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < NV; i++) begin
            if (i == 3) mark = dv_times.size();
            if (!vecs[i].b2b) idle_cycle(1'b1);
            idle_cycle(1'b0);
            run_body(vecs[i].p, vecs[i].pen, vecs[i].data, vecs[i].glitch,
                     vecs[i].perr, vecs[i].serr, vecs[i].noise, vecs[i].exp_dv,
                     -1, seen);
            cmp_int($sformatf("vec%0d_deser", i), seen, vecs[i].exp_deser);
        end
        idle_cycle(1'b1);

        // A 320-cycle frame plus the one IDLE cycle in which the next start bit is seen.
        cmp_int("b2b_dv_pulses", int'(dv_times.size() > mark + 1), 1);
        if (dv_times.size() > mark + 1)
            cmp_int("b2b_dv_spacing", dv_times[mark+1] - dv_times[mark], 10 * 32 + 1);

        // Reset in the middle of data bit 4, released with the line already low.
        idle_cycle(1'b0);
        run_body(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 8 + 3, seen);
        #2 RST = 1'b0;
        #1 cmp_out("async_reset", idle_exp(1'b0));
        @(posedge CLK); #1 cmp_out("reset_held", idle_exp(1'b0));
        @(negedge CLK);
        RST = 1'b1;
        bus.RX_IN = 1'b0;
        @(posedge CLK); #1 cmp_out("release_edge1", idle_exp(1'b0));
        @(posedge CLK); #1;
        run_body(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, seen);
        cmp_int("post_reset_deser", seen, 64);
        idle_cycle(1'b1);

        for (int i = 0; i < 30; i++) begin
            int p;
            bit pen, gl, pe, se, nz, b2b, dv;
            p   = int'(rand_presc());
            pen = rbit();
            gl  = ($urandom_range(0, 7) == 0);
            pe  = ($urandom_range(0, 3) == 0);
            se  = ($urandom_range(0, 3) == 0);
            nz  = rbit();
            b2b = rbit();
            dv  = !gl && !(pen && pe) && !se;
            if (!b2b) idle_cycle(1'b1);
            idle_cycle(1'b0);
            run_body(p, pen, 8'($urandom), gl, pe, se, nz, dv, -1, seen);
            cmp_int($sformatf("rand%0d_deser", i), seen, gl ? 0 : DW * p);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
